aes_host_ctrl: RTL

- Host-side sequencer that drives the AES core top (shared encrypt/decrypt datapath) through its ld/kld/done/kdone handshake.
- Accepts 128-bit block requests on a valid/ready stream and holds mode/key/text stable for the whole operation.
- Performs decrypt key expansion only when needed, captures text_out on done, and returns results on a valid/ready response stream with a timeout error flag.

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_host_tmr.sv | 42 ++++
 rtl/aes_host_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES host-side sequencer.
//   aes_blk_t    : 128-bit block / key type
//   aes_mode_e   : encrypt / decrypt selector
//   host_state_e : sequencer FSM states
package aes_pkg;

  typedef logic [127:0] aes_blk_t;

  typedef enum logic {
    AES_ENC = 1'b0,
    AES_DEC = 1'b1
  } aes_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StKld,
    StKwait,
    StLd,
    StRun,
    StResp
  } host_state_e;

  // Cycles waited for core_done / core_kdone before giving up.
  localparam int unsigned DefaultTimeout = 64;
  // Counter width; 2**DefaultCntW must exceed DefaultTimeout.
  localparam int unsigned DefaultCntW    = 7;

endpackage

// File: rtl/aes_host_tmr.sv
// Saturating wait timer shared by the key-expansion and block wait states.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : count one cycle, saturating at TIMEOUT
//   expired  : counter has reached TIMEOUT
module aes_host_tmr
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/aes_host_ctrl.sv
// Host-side sequencer for the shared encrypt/decrypt AES core.
//   req_*  : valid/ready request stream (mode, key, text)
//   core_* : ld/kld pulses and held mode/key/text to the core; done/kdone/text_out back
//   rsp_*  : valid/ready response stream (text, mode, timeout error)
//   busy   : sequencer not idle
// Decrypt key expansion is skipped when the requested key matches the last fully expanded key.
module aes_host_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [127:0] req_key,
  input  logic [127:0] req_text,
  output logic         core_mode,
  output logic         core_ld,
  output logic         core_kld,
  output logic [127:0] core_key,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic         core_kdone,
  input  logic [127:0] core_text_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_text,
  output logic         rsp_mode,
  output logic         rsp_err,
  output logic         busy
);

  host_state_e state_q, state_d;

  logic     accept, cache_hit, expired, tmr_clr, tmr_en;
  logic     key_cache_vld_q, core_mode_q, rsp_err_q;
  aes_blk_t cached_key_q, core_key_q, core_text_q, rsp_text_q;

  assign accept    = req_valid & req_ready;
  assign cache_hit = key_cache_vld_q && (req_key == cached_key_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a done/kdone on the expiry cycle still counts as success.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (aes_mode_e'(req_mode) == AES_DEC && !cache_hit) ? StKld : StLd;
        end
      end
      StKld:   state_d = StKwait;
      StKwait: begin
        if (core_kdone)   state_d = StLd;
        else if (expired) state_d = StResp;
      end
      StLd:    state_d = StRun;
      StRun: begin
        if (core_done || expired) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; req_ready is gated by reset so every output reads 0 while rst is low.
  always_comb begin
    req_ready = rst && (state_q == StIdle);
    busy      = (state_q != StIdle);
    core_kld  = (state_q == StKld);
    core_ld   = (state_q == StLd);
    rsp_valid = (state_q == StResp);
    tmr_clr   = (state_q == StKld) || (state_q == StLd);
    tmr_en    = (state_q == StKwait) || (state_q == StRun);
  end

  // Holding registers, key cache and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_mode_q     <= 1'b0;
      core_key_q      <= '0;
      core_text_q     <= '0;
      cached_key_q    <= '0;
      key_cache_vld_q <= 1'b0;
      rsp_text_q      <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      if (accept) begin
        core_mode_q <= req_mode;
        core_key_q  <= req_key;
        core_text_q <= req_text;
      end
      case (state_q)
        StKld: begin
          // Cache stays invalid until the expansion actually completes.
          cached_key_q    <= core_key_q;
          key_cache_vld_q <= 1'b0;
        end
        StKwait: begin
          if (core_kdone) begin
            key_cache_vld_q <= 1'b1;
          end else if (expired) begin
            rsp_text_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        StRun: begin
          if (core_done) begin
            rsp_text_q <= core_text_out;
            rsp_err_q  <= 1'b0;
          end else if (expired) begin
            rsp_text_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_mode    = core_mode_q;
  assign core_key     = core_key_q;
  assign core_text_in = core_text_q;
  assign rsp_text     = rsp_text_q;
  assign rsp_mode     = core_mode_q;
  assign rsp_err      = rsp_err_q;

  aes_host_tmr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

endmodule
